ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests and the forwarded operands, computes results over 32 cycles, and holds them in the architectural HI/LO registers. While an operation is in flight it asserts `stall` toward the hazard logic when the instruction in EX needs the unit. One iteration per cycle keeps the path short and the area small.

---
 rtl/ex_muldiv.sv | 128 ++++++++++++
 tb/tb_ex_muldiv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Iterative 32-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        mf_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [31:0] bmag;
   logic        div_op;
   logic        neg_main;
   logic        neg_rem;

   logic        is_signed;
   logic [31:0] amag_in;
   logic [31:0] bmag_in;
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [32:0] div_trial;
   logic [32:0] div_diff;
   logic [63:0] div_step;
   logic [63:0] acc_step;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign is_signed = ~op[0];
   assign amag_in   = (is_signed && a[31]) ? (32'd0 - a) : a;
   assign bmag_in   = (is_signed && b[31]) ? (32'd0 - b) : b;

   // Multiply: acc = {partial product, remaining multiplier bits}, LSB first.
   assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, bmag} : 33'd0);
   assign mul_step = {mul_sum, acc[31:1]};

   // Restoring divide: acc = {remainder, dividend/quotient}, MSB first.
   assign div_trial = acc[63:31];
   assign div_diff  = div_trial - {1'b0, bmag};
   assign div_step  = div_diff[32] ? {div_trial[31:0], acc[30:0], 1'b0}
                                   : {div_diff[31:0],  acc[30:0], 1'b1};

   assign acc_step = div_op ? div_step : mul_step;
   assign prod_fix = neg_main ? (64'd0 - acc_step) : acc_step;
   assign quo_fix  = neg_main ? (32'd0 - acc_step[31:0]) : acc_step[31:0];
   assign rem_fix  = neg_rem  ? (32'd0 - acc_step[63:32]) : acc_step[63:32];

   assign busy  = (state == RUN);
   assign stall = busy & (start | mthi | mtlo | mf_req);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (state == IDLE) begin
         if (start) state_next = RUN;
      end else begin
         if (cnt == 5'd31) state_next = IDLE;
      end
   end

   // Divide by zero: quotient sign is suppressed so LO stays all-ones, and the
   // remainder (|a| with a's sign restored) naturally reproduces a in HI.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= 5'd0;
         acc      <= 64'd0;
         bmag     <= 32'd0;
         div_op   <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
      end else if (state == IDLE) begin
         if (start) begin
            div_op   <= op[1];
            acc      <= {32'd0, amag_in};
            bmag     <= bmag_in;
            neg_main <= is_signed & (a[31] ^ b[31]) & ~(op[1] & (b == 32'd0));
            neg_rem  <= is_signed & a[31] & op[1];
            cnt      <= 5'd0;
         end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
         end
      end else begin
         cnt <= cnt + 5'd1;
         acc <= acc_step;
         if (cnt == 5'd31) begin
            if (div_op) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else begin
               hi <= prod_fix[63:32];
               lo <= prod_fix[31:0];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Scoreboard bench for ex_muldiv with arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic        mf_req = 1'b0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] sb[$];
   bit          skip_next = 1'b0;
   logic        busy_prev = 1'b0;
   int          busy_len = 0;

   ex_muldiv dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .mf_req(mf_req),
      .hi(hi), .lo(lo), .busy(busy), .stall(stall)
   );

   always #5 clk = ~clk;

   // Reference: returns {HI, LO} from plain arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      p;
      int          sx, sy;
      logic [31:0] q, r;
      sx = x;
      sy = y;
      case (o)
         2'b00: begin p = longint'(sx) * longint'(sy); return p; end
         2'b01: return {32'd0, x} * {32'd0, y};
         default: begin
            if (y == 32'd0) return {x, 32'hFFFFFFFF};
            if (o == 2'b10) begin
               if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
               q = sx / sy;
               r = sx % sy;
            end else begin
               q = x / y;
               r = x % y;
            end
            return {r, q};
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: a completed operation is signalled by busy falling.
   always @(negedge clk) begin
      if (busy) busy_len++;
      if (busy_prev && !busy) begin
         if (skip_next) begin
            skip_next = 1'b0;
         end else begin
            check("busy_len", 64'(busy_len), 64'd32);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result: got %h%h expected none (queue empty)", hi, lo);
            end else begin
               check("hilo", {hi, lo}, sb.pop_front());
            end
         end
         busy_len = 0;
      end
      busy_prev = busy;
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL timeout: busy=%b expected 0", busy);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit wait_done);
      start = 1'b1; op = o; a = x; b = y;
      sb.push_back(model(o, x, y));
      @(posedge clk); #1;
      start = 1'b0;
      if (wait_done) wait_idle();
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          scnt;

      @(posedge clk); #1;
      check("reset_state", {29'd0, hi == 0, lo == 0, busy | stall}, {29'd0, 1'b1, 1'b1, 1'b0});
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed cases, each waited to completion.
      issue(2'b00, 32'hFFFFFFFD, 32'd7, 1);
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      issue(2'b11, 32'd100, 32'd7, 1);
      issue(2'b10, 32'hFFFFFFF9, 32'd2, 1);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1);
      issue(2'b10, 32'h12345678, 32'd0, 1);
      issue(2'b11, 32'h12345678, 32'd0, 1);
      issue(2'b10, 32'hEDCBA988, 32'd0, 1);

      // Stall window with a stray start during RUN.
      issue(2'b00, 32'd1234567, 32'hFFFF0001, 0);
      mf_req = 1'b1;
      scnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 5) begin start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; end
         if (i == 7) check("stall_on_start", {63'd0, stall}, 64'd1);
         if (i == 8) start = 1'b0;
         if (!stall) break;
         scnt++;
      end
      check("stall_len", 64'(scnt), 64'd32);
      check("mf_sees_result", {hi, lo}, model(2'b00, 32'd1234567, 32'hFFFF0001));
      @(posedge clk); #1;
      mf_req = 1'b0;
      check("no_restart", {63'd0, busy}, 64'd0);

      // Move-to writes in IDLE.
      mthi = 1'b1; a = 32'hCAFEF00D;
      @(posedge clk); #1;
      mthi = 1'b0;
      check("mthi", {hi, 31'd0, busy}, {32'hCAFEF00D, 32'd0});
      mtlo = 1'b1; a = 32'd1;
      @(posedge clk); #1;
      mtlo = 1'b0;
      check("mtlo", {hi, lo}, {32'hCAFEF00D, 32'd1});
      check("mt_busy", {63'd0, busy}, 64'd0);

      // Random traffic, issued back-to-back as soon as busy drops.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         issue(2'($urandom_range(0, 3)), ra, rb, 1);
      end

      // Asynchronous reset in the middle of a divide.
      issue(2'b10, 32'h7FFFFFFF, 32'd3, 0);
      repeat (9) @(posedge clk);
      #2;
      skip_next = 1'b1;
      void'(sb.pop_back());
      reset = 1'b1;
      #1;
      check("async_reset", {hi, lo}, 64'd0);
      check("async_busy", {62'd0, busy, stall}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      issue(2'b00, 32'd5, 32'd6, 1);

      repeat (3) @(posedge clk);
      check("queue_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
